pc_sequencer: RTL and testbench

- Parametrised, stateful successor to the fetch-stage PC logic; owns the architectural fetch PC register.
- Each cycle it selects one action: sequential increment, hold on stall, redirect on a resolved branch, or halt.
- Evaluates the 3-bit branch condition code against the Z/V/N flags.
- Computes offset targets with a sign-extended immediate and drives a pipeline flush on every taken redirect.
- Sits between the fetch stage (PC output) and the execute stage (branch resolution inputs).

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, resolves branch conditions and
// selects increment / hold / redirect / halt each cycle.
//
// state  | meaning
// S_RUN  | fetching: increment, hold on stall, or redirect on taken branch
// S_HALT | HLT decoded; PC frozen until an older taken branch or reset
module pc_sequencer #(
  parameter int              AW       = 16,
  parameter int              IMM_W    = 9,
  parameter int              INC      = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt_dec,
  input  logic             br_valid,
  input  logic             br_type,
  input  logic [2:0]       br_cond,
  input  logic [2:0]       flags,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [AW-1:0]    br_pc,
  input  logic [AW-1:0]    br_reg,
  output logic [AW-1:0]    pc,
  output logic             flush,
  output logic             taken,
  output logic             halted
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t        state;
  logic          cond_true;
  logic [AW-1:0] imm_ext;
  logic [AW-1:0] off_tgt;
  logic [AW-1:0] br_tgt;
  logic          flag_z;
  logic          flag_v;
  logic          flag_n;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = ~flag_n;
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  // Immediate is in instruction words; the shift converts it to bytes.
  assign imm_ext = {{(AW-IMM_W){br_imm[IMM_W-1]}}, br_imm};
  assign off_tgt = br_pc + AW'(INC) + {imm_ext[AW-2:0], 1'b0};
  assign br_tgt  = br_type ? br_reg : off_tgt;

  // Gated by rst_n so nothing leaks out while reset is held.
  assign taken = rst_n & br_valid & cond_true;
  assign flush = taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      state  <= S_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (taken) begin
            pc <= br_tgt;
          end else if (halt_dec && !stall) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!stall) begin
            pc <= pc + AW'(INC);
          end
        end
        S_HALT: begin
          if (taken) begin
            pc     <= br_tgt;
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (16-bit and 20-bit) checked every
// cycle against an arithmetic model, plus directed literal expectations.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, stall, halt_dec, br_valid, br_type;
  logic [2:0]  br_cond [2];
  logic [2:0]  flags   [2];
  logic [31:0] br_imm  [2];
  logic [31:0] br_pc   [2];
  logic [31:0] br_reg  [2];

  logic [15:0] pc0;
  logic [19:0] pc1;
  logic        flush0, flush1, taken0, taken1, halted0, halted1;

  pc_sequencer #(.AW(16), .IMM_W(9), .INC(2), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .stall(stall[0]), .halt_dec(halt_dec[0]),
    .br_valid(br_valid[0]), .br_type(br_type[0]), .br_cond(br_cond[0]),
    .flags(flags[0]), .br_imm(br_imm[0][8:0]), .br_pc(br_pc[0][15:0]),
    .br_reg(br_reg[0][15:0]), .pc(pc0), .flush(flush0), .taken(taken0),
    .halted(halted0));

  pc_sequencer #(.AW(20), .IMM_W(12), .INC(2), .RESET_PC(20'h80000)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .stall(stall[1]), .halt_dec(halt_dec[1]),
    .br_valid(br_valid[1]), .br_type(br_type[1]), .br_cond(br_cond[1]),
    .flags(flags[1]), .br_imm(br_imm[1][11:0]), .br_pc(br_pc[1][19:0]),
    .br_reg(br_reg[1][19:0]), .pc(pc1), .flush(flush1), .taken(taken1),
    .halted(halted1));

  int total = 0;
  int bad   = 0;

  // Model configuration and state per channel.
  int          m_aw   [2] = '{16, 20};
  int          m_immw [2] = '{9, 12};
  longint      m_rpc  [2] = '{64'h0, 64'h80000};
  longint      m_pc   [2] = '{64'h0, 64'h80000};
  bit          m_halt [2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic longint mask(input int ch);
    return (longint'(1) << m_aw[ch]) - 1;
  endfunction

  function automatic longint target(input int ch);
    longint imm;
    imm = longint'(br_imm[ch]) & ((longint'(1) << m_immw[ch]) - 1);
    if (imm >= (longint'(1) << (m_immw[ch] - 1))) imm = imm - (longint'(1) << m_immw[ch]);
    if (br_type[ch]) return longint'(br_reg[ch]) & mask(ch);
    return (longint'(br_pc[ch]) + 2 + imm * 2) & mask(ch);
  endfunction

  function automatic bit exp_taken(input int ch);
    return rst_n[ch] && br_valid[ch] && cond_ok(br_cond[ch], flags[ch]);
  endfunction

  always @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n[ch]) begin
        m_pc[ch] = m_rpc[ch]; m_halt[ch] = 1'b0;
      end else if (exp_taken(ch)) begin
        m_pc[ch] = target(ch); m_halt[ch] = 1'b0;
      end else if (!m_halt[ch]) begin
        if (halt_dec[ch] && !stall[ch]) m_halt[ch] = 1'b1;
        else if (!stall[ch]) m_pc[ch] = (m_pc[ch] + 2) & mask(ch);
      end
    end
  end

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n[ch]) begin
        m_pc[ch] = m_rpc[ch]; m_halt[ch] = 1'b0;
      end
    end
    chk("model pc0",     longint'(pc0),   m_pc[0]);
    chk("model halted0", longint'(halted0), longint'(m_halt[0]));
    chk("model taken0",  longint'(taken0),  longint'(exp_taken(0)));
    chk("model flush0",  longint'(flush0),  longint'(exp_taken(0)));
    chk("model pc1",     longint'(pc1),   m_pc[1]);
    chk("model halted1", longint'(halted1), longint'(m_halt[1]));
    chk("model taken1",  longint'(taken1),  longint'(exp_taken(1)));
    chk("model flush1",  longint'(flush1),  longint'(exp_taken(1)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int ch, input bit st, input bit hd, input bit bv,
                       input bit bt, input logic [2:0] c, input logic [2:0] f,
                       input logic [31:0] imm, input logic [31:0] bpc,
                       input logic [31:0] breg);
    stall[ch] = st; halt_dec[ch] = hd; br_valid[ch] = bv; br_type[ch] = bt;
    br_cond[ch] = c; flags[ch] = f; br_imm[ch] = imm; br_pc[ch] = bpc;
    br_reg[ch] = breg;
  endtask

  task automatic idle(input int ch);
    apply(ch, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 2'b00;
    idle(0);
    idle(1);
    tick(); tick();
    #3 rst_n = 2'b11;
    #1;
    chk("reset pc0", longint'(pc0), 64'h0);
    chk("reset halted0", longint'(halted0), 0);
    chk("reset pc1", longint'(pc1), 64'h80000);

    // Sequential fetch after reset release.
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq pc0", longint'(pc0), longint'(2 * i));
    end

    // EQ taken, offset branch, negative immediate.
    apply(0, 0, 0, 1, 0, 3'b001, 3'b100, 32'h1FE, 32'h10, 0);
    #1 chk("eq taken", longint'(taken0), 1);
    chk("eq flush", longint'(flush0), 1);
    tick();
    chk("eq target", longint'(pc0), 64'h000E);

    apply(0, 0, 0, 1, 0, 3'b011, 3'b000, 0, 32'h40, 0);
    #1 chk("lt not taken", longint'(taken0), 0);
    tick();
    chk("lt not taken pc", longint'(pc0), 64'h0010);

    apply(0, 0, 0, 1, 1, 3'b011, 3'b001, 0, 0, 32'h4000);
    tick();
    chk("lt reg target", longint'(pc0), 64'h4000);

    // Taken branch overrides stall.
    apply(0, 1, 0, 1, 1, 3'b111, 3'b000, 0, 0, 32'h20);
    tick();
    chk("stall override", longint'(pc0), 64'h0020);

    apply(0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0);
    tick();
    chk("stall+halt pc", longint'(pc0), 64'h0020);
    chk("stall+halt run", longint'(halted0), 0);

    apply(0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0);
    tick();
    chk("enter halt", longint'(halted0), 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, i[0], 1, 0, 0, 3'd0, 3'd0, 0, 0, 0);
      tick();
      chk("halt hold pc", longint'(pc0), 64'h0020);
    end

    apply(0, 0, 0, 1, 0, 3'b000, 3'b100, 32'h4, 32'h1C, 0);
    tick();
    chk("halt not-taken", longint'(halted0), 1);

    apply(0, 0, 0, 1, 0, 3'b111, 3'b000, 32'h4, 32'h1C, 0);
    #1 chk("halt exit flush", longint'(flush0), 1);
    tick();
    chk("halt exit pc", longint'(pc0), 64'h0026);
    chk("halt exit run", longint'(halted0), 0);

    // Wrap-around of increment and offset target.
    apply(0, 0, 0, 1, 1, 3'b111, 3'b000, 0, 0, 32'hFFFC);
    tick();
    idle(0);
    tick();
    chk("pre-wrap", longint'(pc0), 64'hFFFE);
    tick();
    chk("inc wrap", longint'(pc0), 64'h0000);
    apply(0, 0, 0, 1, 0, 3'b010, 3'b000, 32'h1FC, 32'h2, 0);
    tick();
    chk("offset wrap", longint'(pc0), 64'hFFFC);

    // Asynchronous reset in the middle of a cycle.
    apply(0, 0, 0, 1, 1, 3'b111, 3'b000, 0, 0, 32'h1234);
    #2 rst_n[0] = 1'b0;
    #1 chk("async rst pc", longint'(pc0), 64'h0);
    chk("async rst taken", longint'(taken0), 0);
    idle(0);
    tick();
    #2 rst_n[0] = 1'b1;
    tick();
    chk("post rst pc", longint'(pc0), 64'h0002);

    // 20-bit instance.
    apply(1, 0, 0, 1, 1, 3'b111, 3'b000, 0, 0, 32'h80000);
    tick();
    chk("w20 redirect", longint'(pc1), 64'h80000);
    idle(1);
    tick();
    chk("w20 inc", longint'(pc1), 64'h80002);
    apply(1, 0, 0, 1, 0, 3'b001, 3'b100, 32'hFFE, 32'h80010, 0);
    tick();
    chk("w20 eq offset", longint'(pc1), 64'h8000E);
    apply(1, 0, 0, 1, 0, 3'b111, 3'b000, 32'h001, 32'hFFFFE, 0);
    tick();
    chk("w20 offset wrap", longint'(pc1), 64'h00002);
    apply(1, 0, 0, 1, 0, 3'b100, 3'b001, 0, 0, 0);
    tick();
    chk("w20 ge not taken", longint'(pc1), 64'h00004);
    apply(1, 0, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0);
    tick();
    chk("w20 halt", longint'(halted1), 1);
    apply(1, 0, 0, 1, 1, 3'b110, 3'b010, 0, 0, 32'h12345);
    tick();
    chk("w20 ov exit", longint'(pc1), 64'h12345);
    idle(1);
    #2 rst_n[1] = 1'b0;
    #1 chk("w20 async rst", longint'(pc1), 64'h80000);
    tick();
    #2 rst_n[1] = 1'b1;
    tick();
    chk("w20 post rst", longint'(pc1), 64'h80002);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
